// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and sizes for the 4:1 byte-mux arbiter
package mux_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 16;
    localparam int BEAT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// rtl/mux_arb_rr_pick.sv - combinational rotating-priority picker
// Searches last+1, last+2, ... last; the nearest requester after last wins.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = |req;
        idx  = last;
        cand = '0;
        // Walk from farthest to nearest so the nearest match overwrites.
        for (int off = N_REQ; off >= 1; off--) begin
            cand = last + SEL_W'(off);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter/sequencer for the shared 4:1 byte mux
// Optional grant statistics are enabled with MUX_ARB_STATS_EN.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel,
    output logic [N_REQ-1:0]        gnt
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              stage_free;
    logic              beat;
    logic              burst_done;

    mux_arb_rr_pick u_pick (
        .req  (req_valid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign sel_valid  = req_valid[sel_q];
    assign sel_data   = req_data[sel_q*DATA_W +: DATA_W];
    assign stage_free = !out_valid_q || out_ready;
    assign beat       = (state_q == BUSY) && sel_valid && stage_free;
    assign burst_done = (beat_cnt_q + 1'b1) == BEAT_W'(MAX_BURST);

    always_comb begin
        req_ready = '0;
        if (state_q == BUSY) begin
            req_ready[sel_q] = stage_free;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BUSY;
                    sel_d      = pick_idx;
                    gnt_d      = sel_onehot(pick_idx);
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A stalled requester keeps its grant; only a full burst or a dropped valid releases.
                if ((beat && burst_done) || !sel_valid) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = sel_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (beat) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(N_REQ - 1);
            gnt_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [N_REQ*CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (state_q == IDLE && pick_any) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pick_idx == SEL_W'(i) &&
                    grant_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    grant_cnt_d[i*CNT_W +: CNT_W] = grant_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - scoreboard bench for mux_arbiter (stats checks with MUX_ARB_STATS_EN)
module tb_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  sel;
    logic [3:0]  gnt;
`ifdef MUX_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    mux_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt)
`ifdef MUX_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rbuf [4][16];
    int         rhead [4];
    int         rtail [4];
    logic [3:0] en;
    logic [3:0] hs;

    logic [7:0] exp_out [$];
    logic [3:0] exp_gnt [$];
    int         exp_beats [$];

    bit         in_grant;
    int         cur_beats;
    int         cur_exp_beats;
    logic [1:0] last_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (en[i] && rhead[i] < rtail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = rbuf[i][rhead[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push_req(input int i, input logic [7:0] b);
        rbuf[i][rtail[i]] = b;
        rtail[i]++;
    endtask

    task automatic clear_reqs();
        en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        drive_reqs();
    endtask

    task automatic expect_grant(input logic [3:0] g, input int beats);
        exp_gnt.push_back(g);
        exp_beats.push_back(beats);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_reqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (rhead[i] < rtail[i]) done = 1'b0;
            end
            if (exp_out.size() != 0 || exp_gnt.size() != 0 || in_grant || gnt != 4'b0 || out_valid)
                done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain_timeout: got pending=%0d expected 0", name, exp_out.size() + exp_gnt.size());
            exp_out.delete();
            exp_gnt.delete();
            exp_beats.delete();
        end
    endtask

    // Requester models: pop on a handshake seen between edges.
    always begin
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i] && rhead[i] < rtail[i]) rhead[i]++;
        end
        drive_reqs();
    end

    task automatic close_grant();
        check("burst_beats", 64'(cur_beats), 64'(cur_exp_beats));
        in_grant = 1'b0;
        last_idx = sel;
    endtask

    // Monitor: output bytes and grant sequence against the scoreboard.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %02h expected none", out_data);
            end else begin
                check("out_data", 64'(out_data), 64'(exp_out.pop_front()));
            end
        end
        if (gnt != 4'b0) begin
            if (!in_grant && !rst) begin
                if (exp_gnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected: got %b expected none", gnt);
                    cur_exp_beats = -1;
                end else begin
                    check("gnt_order", 64'(gnt), 64'(exp_gnt.pop_front()));
                    cur_exp_beats = exp_beats.pop_front();
                end
                in_grant  = 1'b1;
                cur_beats = 0;
            end
            check("sel_vs_gnt", 64'(gnt), 64'(4'b0001 << sel));
            check("ready_in_gnt", 64'(req_ready & ~gnt), 64'd0);
            if ((req_valid & req_ready & gnt) != 4'b0) cur_beats++;
        end else begin
            if (in_grant) close_grant();
            check("ready_idle", 64'(req_ready), 64'd0);
            if (!rst) check("sel_hold", 64'(sel), 64'(last_idx));
        end
        if (rst) begin
            if (in_grant) close_grant();
            last_idx = 2'd0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h0;
        in_grant  = 1'b0;
        last_idx  = 2'd0;
        cur_beats = 0;
        cur_exp_beats = 0;
        clear_reqs();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
`ifdef MUX_ARB_STATS_EN
        check("rst_grant_cnt", grant_cnt, 64'd0);
`endif

        // Single requester 2: burst of 4, one idle cycle, regrant for the 5th byte
        tick();
        push_req(2, 8'hdf); push_req(2, 8'hac); push_req(2, 8'h3c);
        push_req(2, 8'h9b); push_req(2, 8'h11);
        exp_out.push_back(8'hdf); exp_out.push_back(8'hac); exp_out.push_back(8'h3c);
        exp_out.push_back(8'h9b); exp_out.push_back(8'h11);
        expect_grant(4'b0100, 4);
        expect_grant(4'b0100, 1);
        en[2] = 1'b1;
        drive_reqs();
        @(negedge clk);
        check("lat_gnt_c0", 64'(gnt), 64'd0);
        @(negedge clk);
        check("lat_gnt_c1", 64'(gnt), 64'b0100);
        check("lat_sel_c1", 64'(sel), 64'd2);
        @(negedge clk);
        check("lat_out_valid_c2", 64'(out_valid), 64'd1);
        check("lat_out_data_c2", 64'(out_data), 64'hdf);
        wait_drain("single");

        // All four continuously valid: 0,1,2,3,0,1,2,3 with 4 beats each
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) push_req(i, 8'(i*16 + k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                expect_grant(4'(1 << i), 4);
                for (int k = 0; k < 4; k++) exp_out.push_back(8'(i*16 + r*4 + k));
            end
        en = 4'b1111;
        drive_reqs();
        wait_drain("all_four");

        // Backpressure mid-burst for 5 cycles
        do_reset();
        push_req(0, 8'ha0); push_req(0, 8'ha1); push_req(0, 8'ha2); push_req(0, 8'ha3);
        exp_out.push_back(8'ha0); exp_out.push_back(8'ha1);
        exp_out.push_back(8'ha2); exp_out.push_back(8'ha3);
        expect_grant(4'b0001, 4);
        en[0] = 1'b1;
        drive_reqs();
        tick(); tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_out_data", 64'(out_data), 64'ha1);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_gnt", 64'(gnt), 64'b0001);
        end
        tick();
        out_ready = 1'b1;
        wait_drain("backpressure");

        // Early release: requester 1 drops after 2 beats, requester 3 next
        do_reset();
        push_req(1, 8'hb0); push_req(1, 8'hb1);
        push_req(3, 8'hc0); push_req(3, 8'hc1);
        exp_out.push_back(8'hb0); exp_out.push_back(8'hb1);
        exp_out.push_back(8'hc0); exp_out.push_back(8'hc1);
        expect_grant(4'b0010, 2);
        expect_grant(4'b1000, 2);
        en = 4'b1010;
        drive_reqs();
        wait_drain("early_release");

        // Reset during beat 3: the third byte never reaches the output
        do_reset();
        for (int k = 0; k < 6; k++) push_req(0, 8'(8'hd0 + k));
        exp_out.push_back(8'hd0); exp_out.push_back(8'hd1);
        expect_grant(4'b0001, 3);
        en[0] = 1'b1;
        drive_reqs();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_reqs();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_sel", 64'(sel), 64'd0);
        tick();
        push_req(0, 8'he0); push_req(2, 8'he2);
        exp_out.push_back(8'he0); exp_out.push_back(8'he2);
        expect_grant(4'b0001, 1);
        expect_grant(4'b0100, 1);
        en = 4'b0101;
        drive_reqs();
        wait_drain("mid_reset");

`ifdef MUX_ARB_STATS_EN
        // Five grants to requester 0, three to requester 3
        do_reset();
        for (int n = 0; n < 8; n++) begin
            int r;
            r = (n < 5) ? 0 : 3;
            push_req(r, 8'(8'h50 + n));
            exp_out.push_back(8'(8'h50 + n));
            expect_grant(4'(1 << r), 1);
            en[r] = 1'b1;
            drive_reqs();
            wait_drain("stats");
        end
        check("grant_cnt0", 64'(grant_cnt[15:0]), 64'd5);
        check("grant_cnt1", 64'(grant_cnt[31:16]), 64'd0);
        check("grant_cnt2", 64'(grant_cnt[47:32]), 64'd0);
        check("grant_cnt3", 64'(grant_cnt[63:48]), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and sequencer for the shared 4:1 8-bit byte mux. Four requesters each present a byte stream with valid/ready handshaking; the block picks one requester, drives the mux select, and forwards up to MAX_BURST bytes from it through a one-entry registered output stage before re-arbitrating. It sits between the requesting sources and the downstream consumer of the muxed byte bus.

## Interface
- DATA_W, 8, width of each requester byte and the output data
- MAX_BURST, 4, max beats per grant (1..15)
- clk  in  1  system clock, rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- req_valid  in  4  per-requester data valid (bit i = requester i)
- req_data  in  4*DATA_W  packed requester data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  4  per-requester accept; at most one bit high
- out_valid  out  1  output byte valid
- out_data  out  DATA_W  output byte
- out_ready  in  1  downstream accept
- sel  out  2  registered mux select = current/last granted index
- gnt  out  4  one-hot grant, all zero when idle
- grant_cnt  out  4*16  per-requester grant counters (only with MUX_ARB_STATS_EN)

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any req_valid, choose first requester set in rotating order last+1, last+2, …, last; register sel=choice, gnt=onehot(choice), beat count=0, enter BUSY. Else stay.
- BUSY: req_ready[sel] = !out_valid | out_ready; other bits 0. Beat = req_valid[sel] & req_ready[sel]; on beat, out_data<=req_data[sel], out_valid<=1, beat count++.
- out_valid clears when out_ready & !beat.
- Release to IDLE (gnt<=0, last<=sel, sel held) when: beat count reaches MAX_BURST (on that beat), or req_valid[sel]=0 in a BUSY cycle. A stall (valid high, ready low) does not release.
- Output stage drains independently of FSM state; a held byte survives release.
- Requesters may deassert valid at any time; beats only counted on handshake.

## Timing
- Reset values: sel=0, gnt=0, req_ready=0, out_valid=0, out_data=0, last=3 (requester 0 wins first), state IDLE, grant_cnt=0.
- Arbitration latency: req_valid rises cycle 0 in IDLE → gnt/sel valid cycle 1 → first beat possible cycle 1 → out_valid cycle 2.
- Minimum gap between grants: one IDLE cycle after every release.
- Throughput: one byte/cycle within a grant while out_ready=1.
- Simultaneous requests: rotating priority only; no starvation (each active requester served within 3 grants).
- Reset mid-burst: all state returns to reset values next edge; in-flight output byte discarded.
- MAX_BURST=1: release after each beat.

## Configuration
- MUX_ARB_STATS_EN defined: grant_cnt port present; counter i increments by 1 on each IDLE→BUSY transition granting i, saturates at 16'hFFFF, cleared by rst.
- Undefined: grant_cnt port and counters absent; arbitration behaviour identical.

## Structure
- Package mux_arb_pkg: state enum (IDLE, BUSY), N_REQ=4, SEL_W=2, CNT_W=16.
- One sub-module mux_arb_rr_pick: combinational rotating-priority picker (req[3:0], last[1:0] → any, idx[1:0]).
- Top holds FSM, beat counter, output register, optional stats.

## Test plan
- Single requester: after reset, requester 2 streams 8'hdf,8'hac,8'h3c,8'h9b,8'h11 with out_ready=1 → gnt=4'b0100 cycle 1, out_data dfac3c9b on cycles 2–5, release, one IDLE cycle, regrant, 8'h11 out.
- All four valid continuously (MAX_BURST=4) → grants in order 0,1,2,3,0; each grant exactly 4 bytes; sel tracks gnt.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_data held stable, req_ready[sel]=0, no release, no byte lost or duplicated.
- Early release: requester 1 drops valid after 2 beats while 3 waits → release, next gnt=4'b1000.
- Reset mid-burst: rst during beat 3 → next cycle out_valid=0, gnt=0, sel=0; next grant goes to requester 0 if requesting.
- With MUX_ARB_STATS_EN: 5 grants to requester 0, 3 to requester 3 → grant_cnt[0]=5, [3]=3, others 0.
